// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package if_fetch_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0]   RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0]   PC_STEP      = 32'd4;

    // One buffered fetch: the instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned; the low two target bits carry no meaning.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-unit boundary: memory request/response, redirect input and decode output.
// Latency: wires only.
// Backpressure: request side valid/ready; response side never stalls; decode side valid/ready.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              if_valid;
    logic              if_ready;
    logic [XLEN-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;

    // Fetch unit side.
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_addr, if_valid, if_pc, if_inst
    );

    // Environment side: next-PC logic, instruction memory and decode.
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_addr, if_valid, if_pc, if_inst
    );

endinterface

// File: rtl/if_fetch_queue.sv
// In-order DEPTH-entry FIFO of {pc, inst} with synchronous flush.
// Latency: a push is visible at the head one cycle later.
// Backpressure: none internally; the caller guarantees no push into a full queue without a pop.
module if_fetch_queue
    import if_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  fetch_entry_t  push_dat_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_dat_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);

    // Flush wins over everything; otherwise pop only a real entry and push when asked.
    always_comb begin
        do_pop   = pop_i && !empty_o && !flush_i;
        do_push  = push_i && !flush_i;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: issues PCs to imem, buffers {pc, inst}, squashes wrong-path fetches.
// Latency: response in cycle N -> if_valid in cycle N+1.
// Backpressure: issue stops once queued + in-flight + to-be-dropped fetches reach DEPTH.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEF,
    parameter int                DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input logic        clk,
    input logic        rst,
    if_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 2;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [SW-1:0]   outstanding;
    logic            req_hs;
    logic            rsp_keep;
    logic            q_pop;
    logic            q_full;
    logic            q_empty;
    logic [CW-1:0]   q_count;
    fetch_entry_t    q_head;
    fetch_entry_t    q_push_dat;

    // Every slot that a response could still land in counts against the cap,
    // including responses we already know will be thrown away.
    assign outstanding        = SW'(q_count) + SW'(inflight_q) + SW'(drop_cnt_q);
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && (outstanding < SW'(DEPTH));
    assign bus.imem_addr      = fetch_pc_q;
    assign req_hs             = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep           = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt_q == '0);
    assign q_pop              = !q_empty && bus.if_ready;
    assign q_push_dat         = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};

    assign bus.if_valid = !q_empty;
    assign bus.if_pc    = q_empty ? '0 : q_head.pc;
    assign bus.if_inst  = q_empty ? NOP_INST : q_head.inst;

    // Next PCs and fetch accounting; a redirect turns every outstanding fetch into a drop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = pc_align(bus.redirect_pc);
            rsp_pc_d   = pc_align(bus.redirect_pc);
            drop_cnt_d = drop_cnt_q + inflight_q - CW'(bus.imem_rsp_valid);
            inflight_d = '0;
        end else begin
            if (req_hs) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
            inflight_d = inflight_q + CW'(req_hs) - CW'(rsp_keep);
            if (bus.imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    // Architectural fetch state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    if_fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rsp_keep),
        .push_dat_i (q_push_dat),
        .pop_i      (q_pop),
        .flush_i    (bus.redirect_valid),
        .head_dat_o (q_head),
        .count_o    (q_count),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    // The issue cap must keep a kept response from ever landing on a full queue.
    assert property (@(posedge clk) disable iff (rst) !(rsp_keep && q_full && !q_pop));

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: in-order memory model plus an epoch-tagged model of the delivered stream.
// Latency: memory latency is programmable per phase.
// Backpressure: decode and memory ready are driven directed, then randomized.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    pend_t       pend[$];   // requests accepted by memory, in order
    ent_t        mq[$];     // what decode must see, in order
    logic [31:0] deliv[$];  // PCs consumed by decode (from the model)
    logic [31:0] m_fpc;
    logic [31:0] m_rpc;
    int          epoch;
    int          cyc;
    int          last_due;
    int          hs_cnt;
    int          total;
    int          bad;
    int          lat_min;
    int          lat_max;
    logic        drv_redir;
    logic        drv_ready;
    logic        drv_mrdy;
    logic [31:0] drv_rpc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_deliv(input int idx, input logic [31:0] exp);
        total++;
        if (idx >= deliv.size()) begin
            bad++;
            $display("FAIL deliv[%0d] missing: only %0d delivered, want=%h", idx, deliv.size(), exp);
        end else if (deliv[idx] !== exp) begin
            bad++;
            $display("FAIL deliv[%0d] got=%h want=%h", idx, deliv[idx], exp);
        end
    endtask

    task automatic drive_idle();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b0;
        drv_redir = 1'b0;
        drv_rpc   = '0;
        drv_ready = 1'b0;
        drv_mrdy  = 1'b0;
    endtask

    task automatic model_clear();
        mq.delete();
        pend.delete();
        deliv.delete();
        m_fpc    = RST_PC;
        m_rpc    = RST_PC;
        epoch    = epoch + 1;
        last_due = cyc;
        hs_cnt   = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        chk({tag, "_if_valid"},  32'(bus.if_valid), 32'd0);
        chk({tag, "_if_pc"},     bus.if_pc, 32'd0);
        chk({tag, "_if_inst"},   bus.if_inst, NOP);
        chk({tag, "_imem_addr"}, bus.imem_addr, RST_PC);
    endtask

    // Called at a falling edge: apply inputs, check outputs, advance the model, end at the next falling edge.
    task automatic step();
        logic  rsp_now;
        logic  hs;
        logic  pop;
        logic  exp_req;
        ent_t  e;
        pend_t p;
        rsp_now = (pend.size() > 0) && (pend[0].due <= cyc);
        bus.redirect_valid = drv_redir;
        bus.redirect_pc    = drv_rpc;
        bus.if_ready       = drv_ready;
        bus.imem_req_ready = drv_mrdy;
        bus.imem_rsp_valid = rsp_now;
        if (rsp_now) bus.imem_rsp_data = mem_word(pend[0].addr);
        else         bus.imem_rsp_data = $urandom;
        #1;
        exp_req = !drv_redir && ((pend.size() + mq.size()) < DEPTH);
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        chk("imem_addr", bus.imem_addr, m_fpc);
        chk("if_valid", 32'(bus.if_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("if_pc", bus.if_pc, mq[0].pc);
            chk("if_inst", bus.if_inst, mq[0].inst);
        end else begin
            chk("if_inst_empty", bus.if_inst, NOP);
        end
        hs  = bus.imem_req_valid && drv_mrdy;
        pop = (mq.size() > 0) && drv_ready && !drv_redir;
        if (drv_redir) begin
            mq.delete();
            epoch = epoch + 1;
            m_fpc = drv_rpc & ~32'd3;
            m_rpc = m_fpc;
            if (rsp_now) pend.delete(0);
        end else begin
            if (pop) begin
                deliv.push_back(mq[0].pc);
                mq.delete(0);
            end
            if (rsp_now) begin
                p = pend[0];
                pend.delete(0);
                if (p.epoch == epoch) begin
                    e.pc   = m_rpc;
                    e.inst = mem_word(m_rpc);
                    mq.push_back(e);
                    m_rpc = m_rpc + 32'd4;
                end
            end
            if (hs) begin
                p.addr  = bus.imem_addr;
                p.epoch = epoch;
                p.due   = cyc + int'($urandom_range(lat_max, lat_min));
                if (p.due <= last_due) p.due = last_due + 1;
                last_due = p.due;
                pend.push_back(p);
                m_fpc  = m_fpc + 32'd4;
                hs_cnt = hs_cnt + 1;
            end
        end
        cyc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int found;
        total = 0;
        bad   = 0;
        cyc   = 0;
        epoch = 0;
        lat_min = 1;
        lat_max = 1;
        drive_idle();
        model_clear();

        // Reset values while rst is held.
        #12;
        check_reset_outputs("reset");

        // 1: one-cycle memory, everything ready.
        @(negedge clk);
        rst = 1'b0;
        drv_ready = 1'b1;
        drv_mrdy  = 1'b1;
        repeat (10) step();
        chk_deliv(0, 32'h0);
        chk_deliv(1, 32'h4);
        chk_deliv(2, 32'h8);

        // 2: decode stalled from reset -> exactly DEPTH fetches, then resume without loss.
        rst = 1'b1;
        drive_idle();
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drv_mrdy  = 1'b1;
        drv_ready = 1'b0;
        repeat (8) step();
        chk("stall_hs_count", 32'(hs_cnt), 32'd2);
        chk("stall_req_low", 32'(bus.imem_req_valid), 32'd0);
        drv_ready = 1'b1;
        repeat (10) step();
        chk_deliv(0, 32'h0);
        chk_deliv(1, 32'h4);
        chk_deliv(2, 32'h8);
        chk_deliv(3, 32'hC);

        // 3: redirect while 0x8 and 0xC are in flight.
        rst = 1'b1;
        drive_idle();
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drv_ready = 1'b1;
        drv_mrdy  = 1'b1;
        lat_min = 3;
        lat_max = 3;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (pend.size() == 2 && pend[0].addr == 32'h8) found = 1;
            else step();
        end
        chk("wait_inflight_8_c", 32'(found), 32'd1);
        chk("pre_redirect_count", 32'(deliv.size()), 32'd2);
        deliv.delete();
        drv_redir = 1'b1;
        drv_rpc   = 32'h100;
        step();
        drv_redir = 1'b0;
        repeat (20) step();
        chk_deliv(0, 32'h100);
        chk_deliv(1, 32'h104);

        // 4: redirect in the same cycle as a response and a pop; unaligned target.
        lat_min = 1;
        lat_max = 1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (pend.size() > 0 && pend[0].due <= cyc && mq.size() > 0) found = 1;
            else step();
        end
        chk("wait_rsp_and_pop", 32'(found), 32'd1);
        deliv.delete();
        drv_redir = 1'b1;
        drv_rpc   = 32'h45;
        step();
        drv_redir = 1'b0;
        chk("flush_if_valid", 32'(bus.if_valid), 32'd0);
        chk("redirect_addr", bus.imem_addr, 32'h44);
        repeat (10) step();
        chk_deliv(0, 32'h44);

        // 5: back-to-back redirects; only the second stream survives.
        lat_min = 3;
        lat_max = 3;
        repeat (3) step();
        deliv.delete();
        drv_redir = 1'b1;
        drv_rpc   = 32'h200;
        step();
        drv_rpc   = 32'h300;
        step();
        drv_redir = 1'b0;
        repeat (25) step();
        chk_deliv(0, 32'h300);
        chk_deliv(1, 32'h304);
        chk("post_redirect_flow", 32'(deliv.size() >= 4), 32'd1);

        // 6: address wrap, then async reset mid-stream.
        lat_min = 1;
        lat_max = 1;
        deliv.delete();
        drv_redir = 1'b1;
        drv_rpc   = 32'hFFFF_FFF8;
        step();
        drv_redir = 1'b0;
        repeat (16) step();
        chk_deliv(0, 32'hFFFF_FFF8);
        chk_deliv(1, 32'hFFFF_FFFC);
        chk_deliv(2, 32'h0000_0000);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        drive_idle();
        model_clear();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drv_ready = 1'b1;
        drv_mrdy  = 1'b1;
        repeat (8) step();
        chk_deliv(0, RST_PC);
        chk_deliv(1, RST_PC + 32'd4);

        // 7: randomized traffic against the model.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            drv_redir = ($urandom_range(99, 0) < 6);
            if ($urandom_range(3, 0) == 0) drv_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            else                           drv_rpc = $urandom;
            drv_ready = ($urandom_range(3, 0) != 0);
            drv_mrdy  = ($urandom_range(3, 0) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
